// File: rtl/instr_prefetch_buffer.sv
// Fetch front end: issues sequential instruction-memory reads and queues the
// returned words with their PCs for decode. A redirect flushes queued and in-flight words.
module instr_prefetch_buffer #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, FLUSH = 2'd2} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] fetch_pc, inflight_pc;
  logic                  inflight;
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] instr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q    [DEPTH];
  logic [CW:0]           used;
  logic                  kill, push, pop;

  // Credit counts the in-flight word so a response always finds a free slot.
  assign used      = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign mem_req   = ~reset & enable & ~redirect & (used < (CW+1)'(DEPTH));
  assign mem_addr  = fetch_pc;
  assign kill      = (state == FLUSH);
  assign push      = inflight & ~kill & ~redirect;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready & ~redirect;
  assign out_instr = instr_q[rd_ptr];
  assign out_pc    = pc_q[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      inflight <= mem_req;
      if (mem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_WIDTH'(1);
      end
      if (redirect)     state <= FLUSH;
      else if (mem_req) state <= FETCH;
      else              state <= IDLE;

      if (redirect) begin
        fetch_pc <= redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          instr_q[wr_ptr] <= mem_rdata;
          pc_q[wr_ptr]    <= inflight_pc;
          wr_ptr          <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: directed scenarios plus a randomized run
// checked against a queue model of requested-but-unconsumed words.
module tb_instr_prefetch_buffer;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset, enable, redirect, out_ready;
  logic [15:0] redirect_pc, mem_addr, mem_rdata, out_instr, out_pc;
  logic        mem_req, out_valid;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clock = ~clock;

  // Synchronous memory: word = addr ^ 0xA5A5, garbage when no request.
  always @(posedge clock) mem_rdata <= mem_req ? (mem_addr ^ 16'hA5A5) : 16'($urandom);

  instr_prefetch_buffer #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(DEPTH), .RESET_PC(16'h0010)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  function automatic logic [15:0] word_of(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  task automatic apply_reset(input logic rdy);
    @(negedge clock);
    reset = 1'b1; enable = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = rdy;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mem_req); end
    n_tests++; if (mem_addr !== 16'h0010) begin n_fail++; $display("FAIL reset_addr: got %h want 0010", mem_addr); end
    n_tests++; if (out_pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h want 0000", out_pc); end
    n_tests++; if (out_instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h want 0000", out_instr); end
  endtask

  task automatic test_stream();
    logic [15:0] e;
    apply_reset(1'b1);
    for (int c = 0; c < 10; c++) begin
      #1;
      n_tests++; if (mem_req !== 1'b1 || mem_addr !== 16'(16'h0010 + c)) begin
        n_fail++; $display("FAIL stream_req c%0d: got %b/%h want 1/%h", c, mem_req, mem_addr, 16'(16'h0010 + c)); end
      if (c < 2) begin
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early c%0d: got %b want 0", c, out_valid); end
      end else begin
        e = 16'(16'h0010 + c - 2);
        n_tests++; if (out_valid !== 1'b1 || out_pc !== e || out_instr !== word_of(e)) begin
          n_fail++; $display("FAIL stream_out c%0d: got %b %h %h want 1 %h %h", c, out_valid, out_pc, out_instr, e, word_of(e)); end
      end
      @(negedge clock);
    end
  endtask

  task automatic test_backpressure();
    int reqs = 0;
    int got  = 0;
    apply_reset(1'b0);
    for (int c = 0; c < 12; c++) begin
      #1;
      if (mem_req) reqs++;
      if (out_valid) begin
        n_tests++; if (out_pc !== 16'h0010) begin n_fail++; $display("FAIL bp_head c%0d: got %h want 0010", c, out_pc); end
      end
      @(negedge clock);
    end
    n_tests++; if (reqs != DEPTH) begin n_fail++; $display("FAIL bp_reqs: got %0d want %0d", reqs, DEPTH); end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      #1;
      if (out_valid) begin
        n_tests++; if (out_pc !== 16'(16'h0010 + got) || out_instr !== word_of(16'(16'h0010 + got))) begin
          n_fail++; $display("FAIL bp_drain %0d: got %h %h want %h", got, out_pc, out_instr, 16'(16'h0010 + got)); end
        got++;
      end
      @(negedge clock);
    end
    n_tests++; if (got != 4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", got); end
  endtask

  task automatic test_redirect_full();
    apply_reset(1'b0);
    repeat (4) @(negedge clock);
    #1;
    n_tests++; if (out_valid !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL rf_pre: got valid %b req %b want 1 0", out_valid, mem_req); end
    redirect = 1'b1; redirect_pc = 16'h0200; out_ready = 1'b1;
    #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rf_req_redir: got %b want 0", mem_req); end
    @(negedge clock); redirect = 1'b0; #1;
    n_tests++; if (out_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0200) begin
      n_fail++; $display("FAIL rf_r1: got %b %b %h want 0 1 0200", out_valid, mem_req, mem_addr); end
    @(negedge clock); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rf_r2: got %b want 0", out_valid); end
    @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_tests++; if (out_valid !== 1'b1 || out_pc !== 16'(16'h0200 + k) || out_instr !== word_of(16'(16'h0200 + k))) begin
        n_fail++; $display("FAIL rf_seq %0d: got %b %h %h want 1 %h", k, out_valid, out_pc, out_instr, 16'(16'h0200 + k)); end
      @(negedge clock);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_pc = 16'hFFFE;
    int got = 0;
    redirect = 1'b1; redirect_pc = 16'hFFFE; out_ready = 1'b1; enable = 1'b1;
    @(negedge clock); redirect = 1'b0;
    for (int c = 0; c < 12 && got < 4; c++) begin
      #1;
      if (out_valid) begin
        n_tests++; if (out_pc !== exp_pc || out_instr !== word_of(exp_pc)) begin
          n_fail++; $display("FAIL wrap %0d: got %h %h want %h", got, out_pc, out_instr, exp_pc); end
        exp_pc = exp_pc + 16'd1;
        got++;
      end
      @(negedge clock);
    end
    n_tests++; if (got != 4) begin n_fail++; $display("FAIL wrap_count: got %0d want 4", got); end
  endtask

  task automatic test_enable_off();
    logic [15:0] nxt = 16'h0010;
    int reqs = 0;
    apply_reset(1'b1);
    for (int c = 0; c < 16; c++) begin
      if (c == 5) enable = 1'b0;
      #1;
      if (c == 5) begin
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL en_off_req: got %b want 0", mem_req); end
      end
      if (mem_req) reqs++;
      if (out_valid && out_ready) begin
        n_tests++; if (out_pc !== nxt) begin n_fail++; $display("FAIL en_seq: got %h want %h", out_pc, nxt); end
        nxt = nxt + 16'd1;
      end
      @(negedge clock);
    end
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL en_drained: got %b want 0", out_valid); end
    n_tests++; if (int'(nxt - 16'h0010) != reqs) begin
      n_fail++; $display("FAIL en_delivered: got %0d want %0d", int'(nxt - 16'h0010), reqs); end
    enable = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    apply_reset(1'b1);
    repeat (4) @(negedge clock);
    #1;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pre: got %b want 1", out_valid); end
    @(posedge clock); #2 reset = 1'b1; #1;
    n_tests++; if (out_valid !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL rm_async: got valid %b req %b want 0 0", out_valid, mem_req); end
    @(negedge clock); reset = 1'b0; #1;
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 16'h0010) begin
      n_fail++; $display("FAIL rm_restart: got %b %h want 1 0010", mem_req, mem_addr); end
    repeat (2) @(negedge clock);
    #1;
    n_tests++; if (out_valid !== 1'b1 || out_pc !== 16'h0010) begin
      n_fail++; $display("FAIL rm_first: got %b %h want 1 0010", out_valid, out_pc); end
    @(negedge clock);
  endtask

  // Model: every issued request is a pending word that becomes visible two
  // cycles after issue and leaves on acceptance; a redirect drops them all.
  task automatic test_random();
    int          pend_cyc[$];
    logic [15:0] pend_pc[$];
    logic [15:0] exp_fetch = 16'h0010;
    logic        exp_valid, exp_req;
    apply_reset(1'b1);
    for (int now = 0; now < 600; now++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      enable      = ($urandom_range(0, 7) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 1) != 0) ? 16'hFFFD : 16'($urandom);
      #1;
      exp_valid = (pend_cyc.size() > 0) && (pend_cyc[0] <= now - 2);
      exp_req   = enable && !redirect && (pend_cyc.size() < DEPTH);
      n_tests++; if (out_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid t%0d: got %b want %b", now, out_valid, exp_valid); end
      if (exp_valid) begin
        n_tests++; if (out_pc !== pend_pc[0] || out_instr !== word_of(pend_pc[0])) begin
          n_fail++; $display("FAIL rnd_out t%0d: got %h %h want %h %h", now, out_pc, out_instr, pend_pc[0], word_of(pend_pc[0])); end
      end
      n_tests++; if (mem_req !== exp_req) begin n_fail++; $display("FAIL rnd_req t%0d: got %b want %b", now, mem_req, exp_req); end
      if (exp_req) begin
        n_tests++; if (mem_addr !== exp_fetch) begin n_fail++; $display("FAIL rnd_addr t%0d: got %h want %h", now, mem_addr, exp_fetch); end
      end
      if (redirect) begin
        pend_cyc.delete(); pend_pc.delete();
        exp_fetch = redirect_pc;
      end else begin
        if (exp_valid && out_ready) begin void'(pend_cyc.pop_front()); void'(pend_pc.pop_front()); end
        if (exp_req) begin
          pend_cyc.push_back(now); pend_pc.push_back(exp_fetch);
          exp_fetch = exp_fetch + 16'd1;
        end
      end
      @(negedge clock);
    end
    redirect = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_wrap();
    test_enable_off();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
